fpu_cvt_arbiter: RTL

//   Shares one multi-cycle signed-int-to-float converter between NUM_REQ requesters.
//   - Round-robin arbitration across requesters.
//   - Drives the converter's input_a/en/rst; captures output_z on complete.
//   - Returns the result with a one-cycle done pulse to the granted requester.
//   - Sits between FPU issue logic and the converter instance.

---
 rtl/fpu_cvt_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fpu_cvt_arbiter.sv
// Round-robin arbiter sharing one int-to-float converter among NUM_REQ requesters.
// Optional watchdog abort when CVT_TIMEOUT_EN is defined.
module fpu_cvt_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [31:0]               cvt_a,
  output logic                      cvt_en,
  output logic                      cvt_rst,
  input  logic                      cvt_complete,
  input  logic [31:0]               cvt_z
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, gid_q, pick;
  logic [NUM_REQ-1:0] hold_q, elig;
  logic [31:0]        a_q, res_q;
  logic               found;

`ifdef CVT_TIMEOUT_EN
  localparam int CW0 = $clog2(TIMEOUT_CYC + 1);
  localparam int CW  = (CW0 > 6) ? CW0 : 6;
  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  assign elig = req & ~hold_q;

  // first eligible requester after the last grant, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (found) state_d = S_RUN;
      S_RUN: begin
        if (cvt_complete) state_d = S_DONE;
`ifdef CVT_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) state_d = S_ABORT;
`endif
      end
`ifdef CVT_TIMEOUT_EN
      S_ABORT: state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      hold_q  <= '0;
      a_q     <= '0;
      res_q   <= '0;
`ifdef CVT_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          hold_q <= '0;
`ifdef CVT_TIMEOUT_EN
          cnt_q  <= '0;
          err_q  <= 1'b0;
`endif
          if (found) begin
            gid_q <= pick;
            ptr_q <= pick;
            a_q   <= 32'(req_data[int'(pick)*DATA_W +: DATA_W]);
          end
        end
        S_RUN: begin
          if (cvt_complete) res_q <= cvt_z;
`ifdef CVT_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
        end
`ifdef CVT_TIMEOUT_EN
        S_ABORT: begin
          res_q <= '0;
          err_q <= 1'b1;
        end
`endif
        S_DONE: hold_q <= NUM_REQ'(1) << gid_q;
        default: ;
      endcase
    end
  end

  assign busy     = !rst && (state_q != S_IDLE);
  assign cvt_en   = !rst && (state_q == S_RUN);
  assign cvt_a    = rst ? '0 : a_q;
  assign done     = (!rst && state_q == S_DONE) ? (NUM_REQ'(1) << gid_q) : '0;
  assign rsp_data = (|done) ? DATA_W'(res_q) : '0;

`ifdef CVT_TIMEOUT_EN
  assign rsp_err  = (|done) & err_q;
  assign cvt_rst  = rst | (state_q == S_ABORT);
`else
  assign rsp_err  = 1'b0;
  assign cvt_rst  = rst;
`endif

endmodule
